// File: rtl/pma_pkg.sv
// Shared definitions for the PMA window lookup block.
//   PMA_ID_W / PMA_DATA_W   : window_id and full entry widths
//   PMA_ID_MSB / PMA_ID_LSB : position of window_id inside an entry
//   PMA_EMPTY_ID            : window_id value marking an unused slot
//   pma_state_e             : lookup controller states
package pma_pkg;

    localparam int PMA_ID_W   = 12;
    localparam int PMA_DATA_W = 144;
    localparam int PMA_ID_MSB = 143;
    localparam int PMA_ID_LSB = 132;

    localparam logic [PMA_ID_W-1:0] PMA_EMPTY_ID = 12'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } pma_state_e;

    // Extracts the window_id field from a full-width entry.
    function automatic logic [PMA_ID_W-1:0] pma_entry_id(input logic [PMA_DATA_W-1:0] entry);
        return entry[PMA_ID_MSB:PMA_ID_LSB];
    endfunction

endpackage

// File: rtl/pma_lookup_pipe.sv
// Delay line that carries {valid, addr} tags alongside the PMA read latency so
// each returning data word arrives together with the slot it came from.
//   clk, rst  : clock and synchronous active-high reset (clears valid tags)
//   flush     : drops every in-flight tag on this edge
//   in_vld    : tag valid for the address issued this cycle
//   in_addr   : address issued this cycle
//   out_vld   : tag valid aligned with the PMA read data
//   out_addr  : address belonging to the PMA read data
module pma_lookup_pipe #(
    parameter int ADDR_W       = 6,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr
);

    generate
        if (READ_LATENCY == 0) begin : g_comb
            // Combinational read port: the issued address is compared in the same cycle.
            assign out_vld  = in_vld;
            assign out_addr = in_addr;
        end else begin : g_reg
            logic              vld_p  [READ_LATENCY];
            logic [ADDR_W-1:0] addr_p [READ_LATENCY];

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    for (int i = 0; i < READ_LATENCY; i++) vld_p[i] <= 1'b0;
                end else begin
                    vld_p[0] <= in_vld;
                    for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
                end
            end

            always_ff @(posedge clk) begin
                addr_p[0] <= in_addr;
                for (int i = 1; i < READ_LATENCY; i++) addr_p[i] <= addr_p[i-1];
            end

            assign out_vld  = vld_p[READ_LATENCY-1];
            assign out_addr = addr_p[READ_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/pma_window_lookup.sv
// Sweeps PMA slots 0..DEPTH-1 looking for the lowest slot whose window_id
// equals the query, and returns that slot and its payload.
//   clk, rst         : clock, synchronous active-high reset
//   query_valid/ready, query_window_id  : query handshake (accepted only in IDLE)
//   pma_read_addr / pma_read_data       : PMA read port (READ_LATENCY cycles)
//   result_valid/ready                  : result handshake, fields held until taken
//   result_hit, result_slot, result_payload : lookup outcome (slot/payload 0 on miss)
module pma_window_lookup
    import pma_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int ADDR_W       = 6,
    parameter int ID_W         = PMA_ID_W,
    parameter int DATA_W       = PMA_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   query_valid,
    output logic                   query_ready,
    input  logic [ID_W-1:0]        query_window_id,
    output logic [ADDR_W-1:0]      pma_read_addr,
    input  logic [DATA_W-1:0]      pma_read_data,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   result_hit,
    output logic [ADDR_W-1:0]      result_slot,
    output logic [DATA_W-ID_W-1:0] result_payload
);

    localparam int                PAY_W     = DATA_W - ID_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    pma_state_e        state_q, state_d;
    logic [ID_W-1:0]   qid_q;
    logic [ADDR_W-1:0] issue_addr_q;
    logic              issuing_q;
    logic              tag_vld;
    logic [ADDR_W-1:0] tag_addr;

    logic              accept, issue_vld, cmp_vld, skip, hit, last, scan_end;
    logic [ID_W-1:0]   rd_id;
    logic [PAY_W-1:0]  rd_pay;

    assign rd_id     = pma_read_data[DATA_W-1 -: ID_W];
    assign rd_pay    = pma_read_data[PAY_W-1:0];
    assign accept    = query_valid && query_ready;
    assign issue_vld = (state_q == SCAN) && issuing_q;
    assign cmp_vld   = (state_q == SCAN) && tag_vld;
    // An empty-id query spends one cycle in SCAN with nothing issued, then reports a miss.
    assign skip      = (state_q == SCAN) && (qid_q == PMA_EMPTY_ID);
    assign hit       = cmp_vld && !skip && (rd_id == qid_q);
    assign last      = cmp_vld && (tag_addr == LAST_ADDR);
    assign scan_end  = hit || last || skip;

    // ---- issue stage: address register feeding the PMA and the tag line ----
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_addr_q <= '0;
            issuing_q    <= 1'b0;
        end else if (accept) begin
            issue_addr_q <= '0;
            issuing_q    <= (query_window_id != PMA_EMPTY_ID);
        end else if (state_q == SCAN) begin
            if (scan_end || (issuing_q && issue_addr_q == LAST_ADDR)) begin
                issuing_q <= 1'b0;
            end else if (issuing_q) begin
                issue_addr_q <= issue_addr_q + 1'b1;
            end
        end
    end

    assign pma_read_addr = issue_addr_q;

    always_ff @(posedge clk) begin
        if (accept) qid_q <= query_window_id;
    end

    pma_lookup_pipe #(
        .ADDR_W       (ADDR_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (scan_end),
        .in_vld   (issue_vld),
        .in_addr  (issue_addr_q),
        .out_vld  (tag_vld),
        .out_addr (tag_addr)
    );

    // ---- FSM ----
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)       state_d = SCAN;
            SCAN:    if (scan_end)     state_d = DONE;
            DONE:    if (result_ready) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_comb begin
        query_ready = (state_q == IDLE);
    end

    // ---- compare stage: result registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            result_valid   <= 1'b0;
            result_hit     <= 1'b0;
            result_slot    <= '0;
            result_payload <= '0;
        end else if (scan_end) begin
            result_valid   <= 1'b1;
            result_hit     <= hit;
            result_slot    <= hit ? tag_addr : '0;
            result_payload <= hit ? rd_pay : '0;
        end else if (state_q == DONE && result_ready) begin
            result_valid   <= 1'b0;
        end
    end

endmodule
